// File: rtl/local_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one router local injection port among NUM_REQ sources.
// Optional per-requester completed-packet counters are enabled by defining ARB_PKT_CNT_EN.
module local_inject_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            Valid_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_req,
   input  logic [NUM_REQ-1:0]            Last_req,
   output logic [NUM_REQ-1:0]            Ready_req,
   output logic                          Valid_out,
   output logic [DATA_WIDTH-1:0]         Data_out,
   output logic                          Last_out,
   input  logic                          Ready_out,
   output logic [IDX_W-1:0]              grant_id,
`ifdef ARB_PKT_CNT_EN
   output logic [NUM_REQ*10-1:0]         pkt_cnt,
`endif
   output logic                          busy
);

   typedef enum logic {StArb, StLock} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] winner;
   logic             found;
   int unsigned      cand;
   logic             hs_tail;

   // Rotating priority: first requesting index at or above rr_ptr, wrapping.
   always_comb begin
      winner = rr_ptr_q;
      found  = 1'b0;
      cand   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && Valid_req[cand]) begin
            found  = 1'b1;
            winner = IDX_W'(cand);
         end
      end
   end

   // Combinational pass-through from the owner while locked.
   always_comb begin
      Valid_out = 1'b0;
      Data_out  = '0;
      Last_out  = 1'b0;
      Ready_req = '0;
      if (state_q == StLock) begin
         Valid_out          = Valid_req[grant_q];
         Ready_req[grant_q] = Ready_out;
         if (Valid_req[grant_q]) begin
            Data_out = Data_req[grant_q*DATA_WIDTH +: DATA_WIDTH];
            Last_out = Last_req[grant_q];
         end
      end
   end

   assign hs_tail = Valid_out & Ready_out & Last_out;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      unique case (state_q)
         StArb: begin
            if (found) begin
               grant_d = winner;
               state_d = StLock;
            end
         end
         StLock: begin
            if (hs_tail) begin
               state_d  = StArb;
               rr_ptr_d = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = StArb;
      endcase
   end

`ifdef ARB_PKT_CNT_EN
   logic [NUM_REQ-1:0][9:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (hs_tail) begin
         cnt_d[grant_q] = cnt_q[grant_q] + 10'd1;
      end
   end

   assign pkt_cnt = cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StArb;
         rr_ptr_q <= '0;
         grant_q  <= '0;
`ifdef ARB_PKT_CNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
`ifdef ARB_PKT_CNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign busy     = (state_q == StLock);
   assign grant_id = grant_q;

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Scoreboard bench for local_inject_arbiter: packet-level round-robin model predicts flit order.
// Counter checks are compiled in when ARB_PKT_CNT_EN is defined.
module tb_local_inject_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [NR-1:0]  Valid_req;
   logic [NR*DW-1:0] Data_req;
   logic [NR-1:0]  Last_req;
   logic [NR-1:0]  Ready_req;
   logic           Valid_out;
   logic [DW-1:0]  Data_out;
   logic           Last_out;
   logic           Ready_out;
   logic [1:0]     grant_id;
   logic           busy;
`ifdef ARB_PKT_CNT_EN
   logic [NR*10-1:0] pkt_cnt;
`endif

   local_inject_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .Valid_req (Valid_req),
      .Data_req  (Data_req),
      .Last_req  (Last_req),
      .Ready_req (Ready_req),
      .Valid_out (Valid_out),
      .Data_out  (Data_out),
      .Last_out  (Last_out),
      .Ready_out (Ready_out),
      .grant_id  (grant_id),
`ifdef ARB_PKT_CNT_EN
      .pkt_cnt   (pkt_cnt),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Flit = {last, data}; expected entry = {id, last, data}.
   logic [32:0] fq[NR][$];
   logic [32:0] mq[NR][$];
   logic [34:0] exp_q[$];
   int          mptr = 0;
   logic [NR-1:0] mid = '0;

   function automatic void check(input string nm, input bit ok, input string msg);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s (t=%0t)", nm, msg, $time);
      end
   endfunction

   task automatic add_pkt(input int r, input int len, input logic [31:0] base);
      for (int j = 0; j < len; j++) begin
         fq[r].push_back({(j == len - 1), base + 32'(j)});
         mq[r].push_back({(j == len - 1), base + 32'(j)});
      end
   endtask

   // Reference: serve whole packets in rotating order starting at mptr.
   task automatic plan();
      int w;
      int c;
      logic [32:0] f;
      while (1) begin
         w = -1;
         for (int k = 0; k < NR; k++) begin
            c = (mptr + k) % NR;
            if (w < 0 && mq[c].size() > 0) w = c;
         end
         if (w < 0) break;
         do begin
            f = mq[w].pop_front();
            exp_q.push_back({w[1:0], f});
         end while (!f[32]);
         mptr = (w + 1) % NR;
      end
   endtask

   function automatic bit pending();
      pending = 1'b0;
      for (int i = 0; i < NR; i++) if (fq[i].size() > 0) pending = 1'b1;
   endfunction

   task automatic flush_all();
      for (int i = 0; i < NR; i++) begin
         fq[i].delete();
         mq[i].delete();
      end
      exp_q.delete();
      mid = '0;
   endtask

   task automatic idle(input int n);
      Valid_req = '0;
      Last_req  = '0;
      Data_req  = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < n; c++) begin
         Ready_out = ($urandom_range(0, 1) == 1);
         @(posedge clk);
         #1;
      end
   endtask

   // Runs cycles until all queued flits are accepted or max_hs handshakes occurred.
   task automatic run_round(input int rdy_pct, input int max_hs);
      int hs_cnt;
      int cyc;
      logic [NR-1:0] hs;
      logic [32:0] f;
      hs_cnt = 0;
      cyc = 0;
      while (pending() && hs_cnt < max_hs) begin
         if (cyc > 4000) begin
            check("round_timeout", 1'b0, $sformatf("got %0d flits pending want 0", exp_q.size()));
            flush_all();
            break;
         end
         cyc++;
         for (int i = 0; i < NR; i++) begin
            if (fq[i].size() > 0 && !(mid[i] && $urandom_range(0, 3) == 0)) begin
               Valid_req[i]         = 1'b1;
               Last_req[i]          = fq[i][0][32];
               Data_req[i*DW +: DW] = fq[i][0][31:0];
            end else begin
               Valid_req[i]         = 1'b0;
               Last_req[i]          = 1'($urandom_range(0, 1));
               Data_req[i*DW +: DW] = $urandom;
            end
         end
         Ready_out = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         hs = Valid_req & Ready_req;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (hs[i] && fq[i].size() > 0) begin
               f = fq[i].pop_front();
               mid[i] = !f[32];
               hs_cnt++;
            end
         end
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      Valid_req = '0;
      Ready_out = 1'b0;
      flush_all();
      mptr = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Stimulus
   initial begin
      int n;
      reset     = 1'b1;
      Valid_req = '0;
      Last_req  = '0;
      Data_req  = '0;
      Ready_out = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      add_pkt(2, 4, 32'hA0);
      plan();
      run_round(100, 1 << 30);
      idle(2);

      // rr_ptr now 3: 3 must win before 0
      add_pkt(0, 2, 32'h100);
      add_pkt(3, 2, 32'h300);
      plan();
      run_round(100, 1 << 30);
      idle(1);

      for (int p = 0; p < 2; p++) begin
         add_pkt(0, 2, 32'h1000 + 32'(p * 16));
         add_pkt(1, 2, 32'h2000 + 32'(p * 16));
         add_pkt(3, 2, 32'h3000 + 32'(p * 16));
      end
      plan();
      run_round(100, 1 << 30);

      add_pkt(1, 5, 32'hB0);
      add_pkt(0, 3, 32'hC0);
      plan();
      run_round(20, 1 << 30);
      idle(2);

      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < NR; i++) begin
            n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++) add_pkt(i, $urandom_range(1, 4), $urandom);
         end
         if (!pending()) add_pkt($urandom_range(0, NR - 1), 1, $urandom);
         plan();
         run_round((r % 4 == 0) ? 30 : 80, 1 << 30);
         idle($urandom_range(0, 3));
      end

      // Abandon a packet after two flits
      add_pkt(1, 4, 32'hD0);
      plan();
      run_round(100, 2);
      pulse_reset();

      add_pkt(1, 1, 32'hE1);
      add_pkt(2, 2, 32'hE2);
      add_pkt(0, 1, 32'hE0);
      plan();
      run_round(70, 1 << 30);
      idle(2);

`ifdef ARB_PKT_CNT_EN
      pulse_reset();
      for (int p = 0; p < 1025; p++) add_pkt(0, 1, 32'(p));
      plan();
      run_round(100, 1 << 30);
      idle(2);
`endif

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size() == 0,
            $sformatf("got %0d entries left want 0", exp_q.size()));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor / scoreboard
   initial begin
      bit rst_prev = 1'b0;
      bit tail_prev = 1'b0;
      bit req_prev = 1'b0;
      logic [34:0] e;
      logic [3:0] want_rdy;
      int exp_cnt[NR];
`ifdef ARB_PKT_CNT_EN
      logic [NR*10-1:0] want_cnt;
`endif
      for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
            rst_prev  = 1'b1;
            tail_prev = 1'b0;
            req_prev  = 1'b0;
            continue;
         end
         if (rst_prev) begin
            check("reset_state",
                  !busy && !Valid_out && !Last_out && Ready_req == '0 && grant_id == '0
                  && Data_out == '0,
                  $sformatf("got busy=%b vo=%b lo=%b rdy=%b gid=%0d do=%h want all zero",
                            busy, Valid_out, Last_out, Ready_req, grant_id, Data_out));
`ifdef ARB_PKT_CNT_EN
            check("reset_pkt_cnt", pkt_cnt == '0, $sformatf("got %h want 0", pkt_cnt));
`endif
         end
         if (tail_prev) begin
            check("idle_after_tail", !busy, $sformatf("got busy=%b want 0", busy));
`ifdef ARB_PKT_CNT_EN
            for (int i = 0; i < NR; i++) want_cnt[i*10 +: 10] = 10'(exp_cnt[i]);
            check("pkt_cnt", pkt_cnt == want_cnt, $sformatf("got %h want %h", pkt_cnt, want_cnt));
`endif
         end
         if (req_prev) begin
            check("grant_latency", busy, $sformatf("got busy=%b want 1", busy));
         end
         if (!Valid_out) begin
            check("out_zero_when_invalid", Data_out == '0 && !Last_out,
                  $sformatf("got data=%h last=%b want 0/0", Data_out, Last_out));
         end
         if (!busy) begin
            check("arb_quiet", Ready_req == '0 && !Valid_out,
                  $sformatf("got rdy=%b vo=%b want 0/0", Ready_req, Valid_out));
         end
         if (Valid_out && Ready_out) begin
            if (exp_q.size() == 0) begin
               check("flit_unexpected", 1'b0, $sformatf("got data=%h want none", Data_out));
            end else begin
               e = exp_q.pop_front();
               want_rdy = 4'b0001 << e[34:33];
               check("flit", busy && grant_id == e[34:33] && Data_out == e[31:0]
                     && Last_out == e[32] && Ready_req == want_rdy,
                     $sformatf("got id=%0d data=%h last=%b rdy=%b busy=%b want id=%0d data=%h last=%b rdy=%b busy=1",
                               grant_id, Data_out, Last_out, Ready_req, busy,
                               e[34:33], e[31:0], e[32], want_rdy));
               if (e[32]) exp_cnt[e[34:33]] = (exp_cnt[e[34:33]] + 1) % 1024;
            end
         end
         rst_prev  = 1'b0;
         tail_prev = Valid_out && Ready_out && Last_out;
         req_prev  = !busy && (Valid_req != '0);
      end
   end

endmodule
